// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multi-cycle sequencer for the instruction-fetch datapath.
// Steps each instruction through FETCH/DECODE/EXEC/WB (or FETCH/DECODE/BR),
// handshakes with instruction memory and drives the PC write enable and
// branch select of the fetch unit.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      in IDLE, begin fetching next cycle
//   stop_i       sampled in WB/BR; 1 returns to IDLE instead of FETCH
//   mem_ack_i    instruction memory data valid (only honoured in FETCH)
//   opcode_i     opcode field of the instruction register
//   zero_i       ALU zero flag, used by BEQ in the BR cycle
//   mem_req_o    instruction read request
//   ir_we_o      load instruction register (FETCH & mem_ack)
//   pc_we_o      PC write enable
//   branch_o     select branch/jump target into the PC mux
//   alu_start_o  one-cycle ALU launch
//   reg_we_o     register file write enable
//   busy_o       state is not IDLE, HALTED or FAULT
//   halted_o     HALT instruction retired
//   fault_o      illegal opcode or fetch timeout
//   state_o      current state encoding (debug)
//   retired_o    count of completed instructions (wraps silently)
module fetch_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             mem_ack_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  output logic             mem_req_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             branch_o,
  output logic             alu_start_o,
  output logic             reg_we_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_BR     = 3'd5,
    S_HALTED = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [5:0] OpAlu  = 6'b000000;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpHalt = 6'b111111;

  // Last FETCH wait value before a missing ack turns into a fault.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and output decode. Everything except ir_we depends on the
  // state alone (plus opcode/zero in BR), so outputs fall with the async reset.
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    retired_d   = retired_q;
    mem_req_o   = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    branch_o    = 1'b0;
    alu_start_o = 1'b0;
    reg_we_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_o = 1'b1;
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack_i) begin
          ir_we_o = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WaitLast) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        pc_we_o = 1'b1;
        case (opcode_i)
          OpAlu:       state_d = S_EXEC;
          OpBeq, OpJ:  state_d = S_BR;
          OpHalt: begin
            state_d   = S_HALTED;
            retired_d = retired_q + CNT_W'(1);
          end
          default:     state_d = S_FAULT;
        endcase
      end
      S_EXEC: begin
        alu_start_o = 1'b1;
        state_d     = S_WB;
      end
      S_WB: begin
        reg_we_o  = 1'b1;
        retired_d = retired_q + CNT_W'(1);
        state_d   = stop_i ? S_IDLE : S_FETCH;
      end
      S_BR: begin
        branch_o  = 1'b1;
        // Jumps always load the target; BEQ only when the ALU flagged zero.
        pc_we_o   = (opcode_i == OpJ) ? 1'b1 : zero_i;
        retired_d = retired_q + CNT_W'(1);
        state_d   = stop_i ? S_IDLE : S_FETCH;
      end
      S_HALTED, S_FAULT: begin
        state_d = state_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o    = (state_q != S_IDLE) && (state_q != S_HALTED) && (state_q != S_FAULT);
  assign halted_o  = (state_q == S_HALTED);
  assign fault_o   = (state_q == S_FAULT);
  assign state_o   = state_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. A second instance with a
// 4-bit retired counter shares all inputs and is used for the wrap scenario.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        memAck = 1'b0;
  logic [5:0]  opcode = 6'b0;
  logic        zero = 1'b0;

  logic        memReq, irWe, pcWe, branch, aluStart, regWe, busy, halted, fault;
  logic [2:0]  state;
  logic [15:0] retired;

  logic        memReq4, irWe4, pcWe4, branch4, aluStart4, regWe4, busy4, halted4, fault4;
  logic [2:0]  state4;
  logic [3:0]  retired4;

  int nCompared = 0;
  int nMismatched = 0;

  fetch_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rstN), .start_i(start), .stop_i(stop),
    .mem_ack_i(memAck), .opcode_i(opcode), .zero_i(zero),
    .mem_req_o(memReq), .ir_we_o(irWe), .pc_we_o(pcWe), .branch_o(branch),
    .alu_start_o(aluStart), .reg_we_o(regWe), .busy_o(busy),
    .halted_o(halted), .fault_o(fault), .state_o(state), .retired_o(retired)
  );

  fetch_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rstN), .start_i(start), .stop_i(stop),
    .mem_ack_i(memAck), .opcode_i(opcode), .zero_i(zero),
    .mem_req_o(memReq4), .ir_we_o(irWe4), .pc_we_o(pcWe4), .branch_o(branch4),
    .alu_start_o(aluStart4), .reg_we_o(regWe4), .busy_o(busy4),
    .halted_o(halted4), .fault_o(fault4), .state_o(state4), .retired_o(retired4)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge and let outputs settle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Clean restart: reset asserted for one edge, all inputs idle.
  task automatic doReset();
    start = 1'b0; stop = 1'b0; memAck = 1'b0; opcode = 6'b0; zero = 1'b0;
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    tick();
    nCompared++;
    if (state !== 3'd0) begin nMismatched++; $display("[TB] FAIL reset_state: got %0d, expected 0", state); end
    nCompared++;
    if ({memReq, irWe, pcWe, branch, aluStart, regWe, busy, halted, fault} !== 9'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got %b, expected 000000000",
               {memReq, irWe, pcWe, branch, aluStart, regWe, busy, halted, fault});
    end
    nCompared++;
    if (retired !== 16'd0) begin nMismatched++; $display("[TB] FAIL reset_retired: got %0d, expected 0", retired); end
    rstN = 1'b1;
    tick();
    nCompared++;
    if (state !== 3'd0) begin nMismatched++; $display("[TB] FAIL idle_hold: got %0d, expected 0", state); end
  endtask

  task automatic test_alu();
    doReset();
    start = 1'b1; memAck = 1'b1; opcode = 6'b000000;
    tick();
    nCompared++;
    if ({state, memReq, irWe} !== {3'd1, 1'b1, 1'b1}) begin
      nMismatched++; $display("[TB] FAIL alu_fetch: got st=%0d req=%b irwe=%b, expected st=1 req=1 irwe=1", state, memReq, irWe);
    end
    start = 1'b0;
    tick();
    nCompared++;
    if ({state, pcWe, branch} !== {3'd2, 1'b1, 1'b0}) begin
      nMismatched++; $display("[TB] FAIL alu_decode: got st=%0d pcwe=%b br=%b, expected st=2 pcwe=1 br=0", state, pcWe, branch);
    end
    tick();
    nCompared++;
    if ({state, aluStart, pcWe} !== {3'd3, 1'b1, 1'b0}) begin
      nMismatched++; $display("[TB] FAIL alu_exec: got st=%0d alu=%b pcwe=%b, expected st=3 alu=1 pcwe=0", state, aluStart, pcWe);
    end
    stop = 1'b1;
    tick();
    nCompared++;
    if ({state, regWe, retired} !== {3'd4, 1'b1, 16'd0}) begin
      nMismatched++; $display("[TB] FAIL alu_wb: got st=%0d regwe=%b ret=%0d, expected st=4 regwe=1 ret=0", state, regWe, retired);
    end
    tick();
    nCompared++;
    if ({state, busy, retired} !== {3'd0, 1'b0, 16'd1}) begin
      nMismatched++; $display("[TB] FAIL alu_done: got st=%0d busy=%b ret=%0d, expected st=0 busy=0 ret=1", state, busy, retired);
    end
    stop = 1'b0;
  endtask

  task automatic test_branch();
    doReset();
    start = 1'b1; memAck = 1'b1; opcode = 6'b000100; zero = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    nCompared++;
    if ({state, branch, pcWe} !== {3'd5, 1'b1, 1'b1}) begin
      nMismatched++; $display("[TB] FAIL beq_taken: got st=%0d br=%b pcwe=%b, expected st=5 br=1 pcwe=1", state, branch, pcWe);
    end
    zero = 1'b0;
    tick();
    tick();
    tick();
    nCompared++;
    if ({state, branch, pcWe} !== {3'd5, 1'b1, 1'b0}) begin
      nMismatched++; $display("[TB] FAIL beq_not_taken: got st=%0d br=%b pcwe=%b, expected st=5 br=1 pcwe=0", state, branch, pcWe);
    end
    opcode = 6'b000010;
    tick();
    nCompared++;
    if ({state, retired} !== {3'd1, 16'd2}) begin
      nMismatched++; $display("[TB] FAIL beq_retired: got st=%0d ret=%0d, expected st=1 ret=2", state, retired);
    end
    tick();
    tick();
    nCompared++;
    if ({state, branch, pcWe} !== {3'd5, 1'b1, 1'b1}) begin
      nMismatched++; $display("[TB] FAIL jump_pcwe: got st=%0d br=%b pcwe=%b, expected st=5 br=1 pcwe=1", state, branch, pcWe);
    end
    stop = 1'b1;
    tick();
    nCompared++;
    if ({state, retired} !== {3'd0, 16'd3}) begin
      nMismatched++; $display("[TB] FAIL jump_done: got st=%0d ret=%0d, expected st=0 ret=3", state, retired);
    end
    stop = 1'b0;
  endtask

  task automatic test_timeout();
    int fetchCycles;
    int guard;
    doReset();
    start = 1'b1; memAck = 1'b0;
    tick();
    start = 1'b0;
    fetchCycles = 0;
    guard = 0;
    while (state == 3'd1 && guard < 100) begin
      fetchCycles++;
      tick();
      guard++;
    end
    nCompared++;
    if (fetchCycles !== 16) begin nMismatched++; $display("[TB] FAIL timeout_cycles: got %0d, expected 16", fetchCycles); end
    nCompared++;
    if ({state, fault, busy} !== {3'd7, 1'b1, 1'b0}) begin
      nMismatched++; $display("[TB] FAIL timeout_fault: got st=%0d fault=%b busy=%b, expected st=7 fault=1 busy=0", state, fault, busy);
    end
    start = 1'b1;
    tick(); tick(); tick();
    nCompared++;
    if ({state, fault} !== {3'd7, 1'b1}) begin
      nMismatched++; $display("[TB] FAIL fault_sticky: got st=%0d fault=%b, expected st=7 fault=1", state, fault);
    end
    doReset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    memAck = 1'b1;
    #1;
    nCompared++;
    if ({state, irWe} !== {3'd1, 1'b1}) begin
      nMismatched++; $display("[TB] FAIL ack_last_fetch: got st=%0d irwe=%b, expected st=1 irwe=1", state, irWe);
    end
    tick();
    nCompared++;
    if (state !== 3'd2) begin nMismatched++; $display("[TB] FAIL ack_last_decode: got %0d, expected 2", state); end
  endtask

  task automatic test_illegal_halt();
    doReset();
    start = 1'b1; memAck = 1'b1; opcode = 6'b101010;
    tick();
    start = 1'b0;
    tick();
    tick();
    nCompared++;
    if ({state, fault, retired} !== {3'd7, 1'b1, 16'd0}) begin
      nMismatched++; $display("[TB] FAIL illegal_op: got st=%0d fault=%b ret=%0d, expected st=7 fault=1 ret=0", state, fault, retired);
    end
    doReset();
    start = 1'b1; memAck = 1'b1; opcode = 6'b111111;
    tick();
    start = 1'b0;
    tick();
    tick();
    nCompared++;
    if ({state, halted, fault, busy, retired} !== {3'd6, 1'b1, 1'b0, 1'b0, 16'd1}) begin
      nMismatched++; $display("[TB] FAIL halt: got st=%0d halted=%b fault=%b busy=%b ret=%0d, expected st=6 halted=1 fault=0 busy=0 ret=1",
                              state, halted, fault, busy, retired);
    end
    start = 1'b1;
    tick(); tick(); tick();
    nCompared++;
    if ({state, halted, retired} !== {3'd6, 1'b1, 16'd1}) begin
      nMismatched++; $display("[TB] FAIL halt_sticky: got st=%0d halted=%b ret=%0d, expected st=6 halted=1 ret=1", state, halted, retired);
    end
    doReset();
    nCompared++;
    if ({state, halted, retired} !== {3'd0, 1'b0, 16'd0}) begin
      nMismatched++; $display("[TB] FAIL halt_cleared: got st=%0d halted=%b ret=%0d, expected st=0 halted=0 ret=0", state, halted, retired);
    end
  endtask

  task automatic test_reset_midway();
    doReset();
    start = 1'b1; memAck = 1'b1; opcode = 6'b000000;
    tick();
    start = 1'b0;
    repeat (7) tick();
    nCompared++;
    if ({state, regWe, retired} !== {3'd4, 1'b1, 16'd1}) begin
      nMismatched++; $display("[TB] FAIL pre_reset_wb: got st=%0d regwe=%b ret=%0d, expected st=4 regwe=1 ret=1", state, regWe, retired);
    end
    rstN = 1'b0;
    #1;
    nCompared++;
    if ({state, regWe, pcWe, retired} !== {3'd0, 1'b0, 1'b0, 16'd0}) begin
      nMismatched++; $display("[TB] FAIL reset_in_wb: got st=%0d regwe=%b pcwe=%b ret=%0d, expected st=0 regwe=0 pcwe=0 ret=0",
                              state, regWe, pcWe, retired);
    end
    tick();
    rstN = 1'b1;
    memAck = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    nCompared++;
    if ({state, memReq} !== {3'd1, 1'b1}) begin
      nMismatched++; $display("[TB] FAIL pre_reset_fetch: got st=%0d req=%b, expected st=1 req=1", state, memReq);
    end
    rstN = 1'b0;
    #1;
    nCompared++;
    if ({state, memReq, busy} !== {3'd0, 1'b0, 1'b0}) begin
      nMismatched++; $display("[TB] FAIL reset_in_fetch: got st=%0d req=%b busy=%b, expected st=0 req=0 busy=0", state, memReq, busy);
    end
    tick();
    rstN = 1'b1;
  endtask

  task automatic test_stop_start();
    doReset();
    start = 1'b1; stop = 1'b1; memAck = 1'b1; opcode = 6'b000000;
    repeat (4) tick();
    nCompared++;
    if (state !== 3'd4) begin nMismatched++; $display("[TB] FAIL start_while_busy: got %0d, expected 4", state); end
    tick();
    nCompared++;
    if (state !== 3'd0) begin nMismatched++; $display("[TB] FAIL stop_start_idle: got %0d, expected 0", state); end
    tick();
    nCompared++;
    if (state !== 3'd1) begin nMismatched++; $display("[TB] FAIL stop_start_fetch: got %0d, expected 1", state); end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    doReset();
    start = 1'b1; memAck = 1'b1; opcode = 6'b000000;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      tick(); tick(); tick();
      if (n == 17) stop = 1'b1;
      tick();
      nCompared++;
      if (retired4 !== 4'(n % 16)) begin
        nMismatched++; $display("[TB] FAIL wrap_count_%0d: got %0d, expected %0d", n, retired4, n % 16);
      end
    end
    nCompared++;
    if ({state4, retired} !== {3'd0, 16'd17}) begin
      nMismatched++; $display("[TB] FAIL back_to_back_end: got st=%0d ret=%0d, expected st=0 ret=17", state4, retired);
    end
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_timeout();
    test_illegal_halt();
    test_reset_midway();
    test_stop_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
